mmio_uart_tx: RTL

Synthesizable console transmitter that replaces the simulation-only character dump at the CPU's MMIO window.
- Sits directly downstream of riscv_cpu's data-memory port, in parallel with data memory.
- Decodes stores to the MMIO window and buffers characters in a FIFO.
- Serializes characters as 8N1 on a single tx line and exposes a readable status register.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx_fifo.sv | 64 ++++++
 rtl/mmio_uart_tx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : register map, STATUS bit positions and TX FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

   localparam logic [9:0] TXDATA_OFF = 10'd0;
   localparam logic [9:0] STATUS_OFF = 10'd4;

   localparam int ST_FULL      = 0;
   localparam int ST_EMPTY     = 1;
   localparam int ST_BUSY      = 2;
   localparam int ST_OVF       = 3;
   localparam int ST_COUNT_LSB = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// uart_tx_fifo : synchronous show-ahead FIFO; push while full is taken if a pop
// happens in the same cycle. Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/mmio_uart_tx.sv
// ============================================================================
// mmio_uart_tx : MMIO-decoded console transmitter, FIFO-buffered 8N1 serializer
// Rev 1.0
// ============================================================================
`default_nettype none

module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter logic [31:0] MMIO_BASE_ADDR = 32'h1000_0000,
   parameter int          FIFO_DEPTH     = 16,
   parameter int          CLKS_PER_BIT   = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   input  logic [2:0]  funct3,
   output logic [31:0] ReadData,
   output logic        tx,
   output logic        tx_busy
);

   localparam int             CW        = $clog2(FIFO_DEPTH) + 1;
   localparam int             BW        = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   logic          sel;
   logic [9:0]    offset;
   logic          wr_txdata;
   logic          wr_status;
   logic          overflow;
   logic [31:0]   status;

   logic          fifo_pop;
   logic [7:0]    fifo_dout;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;

   tx_state_t     state,    state_next;
   logic [BW-1:0] baud_cnt, baud_next;
   logic [2:0]    bit_idx,  bit_next;
   logic [7:0]    shift,    shift_next;
   logic          tx_next;
   logic          baud_done;

   logic          unused_bits;
   assign unused_bits = ^{funct3, WriteData[31:8], WriteData[7:4], WriteData[2:0]};

   // 33-bit compare keeps the window correct even when it touches 2^32
   assign sel    = ({1'b0, DataAdr} >= {1'b0, MMIO_BASE_ADDR}) &&
                   ({1'b0, DataAdr} <  ({1'b0, MMIO_BASE_ADDR} + 33'd1024));
   assign offset    = DataAdr[9:0];
   assign wr_txdata = MemWrite && sel && (offset == TXDATA_OFF);
   assign wr_status = MemWrite && sel && (offset == STATUS_OFF);

   uart_tx_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_txdata),
      .pop   (fifo_pop),
      .din   (WriteData[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign tx_busy = (state != IDLE) || !fifo_empty;

   always_comb begin
      status                      = '0;
      status[ST_FULL]             = fifo_full;
      status[ST_EMPTY]            = fifo_empty;
      status[ST_BUSY]             = tx_busy;
      status[ST_OVF]              = overflow;
      status[ST_COUNT_LSB +: 8]   = 8'(fifo_count);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ReadData <= '0;
         overflow <= 1'b0;
      end else begin
         if (sel && !MemWrite) begin
            ReadData <= (offset == STATUS_OFF) ? status : 32'd0;
         end
         // a full FIFO still accepts the byte when the serializer pops that cycle
         if (wr_txdata && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
         end else if (wr_status && WriteData[ST_OVF]) begin
            overflow <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
      end else begin
         state    <= state_next;
         baud_cnt <= baud_next;
         bit_idx  <= bit_next;
         shift    <= shift_next;
         tx       <= tx_next;
      end
   end

   assign baud_done = (baud_cnt == BAUD_LAST);

   always_comb begin
      state_next = state;
      baud_next  = baud_cnt;
      bit_next   = bit_idx;
      shift_next = shift;
      tx_next    = tx;
      fifo_pop   = 1'b0;
      case (state)
         IDLE: begin
            tx_next = 1'b1;
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               shift_next = fifo_dout;
               baud_next  = '0;
               tx_next    = 1'b0;
               state_next = START;
            end
         end
         START: begin
            if (baud_done) begin
               baud_next  = '0;
               bit_next   = '0;
               tx_next    = shift[0];
               state_next = DATA;
            end else begin
               baud_next = baud_cnt + 1'b1;
            end
         end
         DATA: begin
            if (baud_done) begin
               baud_next = '0;
               if (bit_idx == 3'd7) begin
                  tx_next    = 1'b1;
                  state_next = STOP;
               end else begin
                  shift_next = {1'b0, shift[7:1]};
                  tx_next    = shift[1];
                  bit_next   = bit_idx + 1'b1;
               end
            end else begin
               baud_next = baud_cnt + 1'b1;
            end
         end
         STOP: begin
            if (baud_done) begin
               baud_next = '0;
               // chain straight into the next start bit so frames have no gap
               if (!fifo_empty) begin
                  fifo_pop   = 1'b1;
                  shift_next = fifo_dout;
                  tx_next    = 1'b0;
                  state_next = START;
               end else begin
                  tx_next    = 1'b1;
                  state_next = IDLE;
               end
            end else begin
               baud_next = baud_cnt + 1'b1;
            end
         end
         default: begin
            tx_next    = 1'b1;
            state_next = IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire
